// File: rtl/multi_channel_ctl_if.sv
// SPI-byte side and regfile/RAM side of the multi-channel LED controller.
// slave = controller, master = SPI/regfile/RAM environment.
interface multi_channel_ctl_if #(
  parameter int CHAN_NUM = 16,
  parameter int CHAN_W   = $clog2(CHAN_NUM),
  parameter int ADDR_W   = 8,
  parameter int REG_NUM  = 8,
  parameter int REG_AW   = $clog2(REG_NUM)
);
  logic                dc_i;
  logic                spi_byte_vld_i;
  logic [7:0]          spi_byte_data_i;
  logic [ADDR_W-1:0]   reg_chan_len_i;
  logic [CHAN_W-1:0]   reg_chan_cnt_i;
  logic                reg_rgbw_i;
  logic [REG_AW-1:0]   reg_rd_addr_o;
  logic                reg_wr_en_o;
  logic [REG_AW-1:0]   reg_wr_addr_o;
  logic [CHAN_NUM-1:0] ram_wr_en_o;
  logic                ram_wr_done_o;
  logic [ADDR_W-1:0]   ram_wr_addr_o;
  logic [3:0]          ram_wr_byte_en_o;
  logic                err_o;

  modport slave (
    input  dc_i, spi_byte_vld_i, spi_byte_data_i,
           reg_chan_len_i, reg_chan_cnt_i, reg_rgbw_i,
    output reg_rd_addr_o, reg_wr_en_o, reg_wr_addr_o,
           ram_wr_en_o, ram_wr_done_o, ram_wr_addr_o, ram_wr_byte_en_o, err_o
  );

  modport master (
    output dc_i, spi_byte_vld_i, spi_byte_data_i,
           reg_chan_len_i, reg_chan_cnt_i, reg_rgbw_i,
    input  reg_rd_addr_o, reg_wr_en_o, reg_wr_addr_o,
           ram_wr_en_o, ram_wr_done_o, ram_wr_addr_o, ram_wr_byte_en_o, err_o
  );
endinterface

// File: rtl/multi_channel_ctl.sv
// Decodes the SPI command/data byte stream into regfile reads/writes and
// one-hot per-channel pixel RAM writes; all outputs registered.
module multi_channel_ctl #(
  parameter int CHAN_NUM = 16,
  parameter int CHAN_W   = $clog2(CHAN_NUM),
  parameter int ADDR_W   = 8,
  parameter int REG_NUM  = 8,
  parameter int REG_AW   = $clog2(REG_NUM)
)(
  input logic               clk_i,
  input logic               rst_n_i,
  multi_channel_ctl_if.slave bus
);
  localparam logic [7:0] CMD_CONF_WR = 8'h2A;
  localparam logic [7:0] CMD_ADDR_WR = 8'h2B;
  localparam logic [7:0] CMD_DATA_WR = 8'h2C;
  localparam logic [7:0] CMD_CONF_RD = 8'h2D;
  localparam logic [REG_AW:0]   REG_CNT  = (REG_AW+1)'(REG_NUM);
  localparam logic [REG_AW-1:0] REG_LAST = REG_AW'(REG_NUM-1);

  typedef enum logic [2:0] {S_IDLE, S_CONF_WR, S_CONF_RD, S_ADDR_WR, S_DATA_WR} state_t;

  state_t              r_state, w_state_nxt;
  logic [REG_AW:0]     r_idx;
  logic [REG_AW-1:0]   r_rd_addr;
  logic [1:0]          r_ab;
  logic [CHAN_W-1:0]   r_start_chan, r_chan, r_cnt;
  logic [ADDR_W-1:0]   r_start_pix, r_pix, r_len;
  logic [1:0]          r_byte;
  logic                r_rgbw;

  logic                r_reg_wr_en, r_done, r_err;
  logic [REG_AW-1:0]   r_reg_wr_addr;
  logic [CHAN_NUM-1:0] r_ram_wr_en;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [3:0]          r_byte_en;

  logic w_cmd, w_dat, w_byte_last, w_pix_last, w_chan_last;
  logic w_err, w_reg_we, w_ram_we, w_done;
  logic [CHAN_W-1:0] w_in_chan;
  logic [ADDR_W-1:0] w_in_pix;

  assign w_cmd       = bus.spi_byte_vld_i && !bus.dc_i;
  assign w_dat       = bus.spi_byte_vld_i &&  bus.dc_i;
  assign w_in_chan   = CHAN_W'(bus.spi_byte_data_i);
  assign w_in_pix    = ADDR_W'(bus.spi_byte_data_i);
  assign w_byte_last = (r_byte == (r_rgbw ? 2'd3 : 2'd2));
  assign w_pix_last  = (r_pix == r_len);
  assign w_chan_last = (r_chan == r_cnt);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_cmd) begin
      case (bus.spi_byte_data_i)
        CMD_CONF_WR: w_state_nxt = S_CONF_WR;
        CMD_CONF_RD: w_state_nxt = S_CONF_RD;
        CMD_ADDR_WR: w_state_nxt = S_ADDR_WR;
        CMD_DATA_WR: w_state_nxt = S_DATA_WR;
        default:     w_state_nxt = S_IDLE;
      endcase
    end else if (w_done) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_comb begin
    w_err    = 1'b0;
    w_reg_we = 1'b0;
    w_ram_we = 1'b0;
    w_done   = 1'b0;
    if (w_cmd) begin
      w_err = !(bus.spi_byte_data_i inside {CMD_CONF_WR, CMD_CONF_RD, CMD_ADDR_WR, CMD_DATA_WR});
    end else if (w_dat) begin
      case (r_state)
        S_IDLE:    w_err = 1'b1;
        S_CONF_WR: begin
          w_reg_we = (r_idx < REG_CNT);
          w_err    = !w_reg_we;
        end
        S_ADDR_WR: begin
          if (r_ab == 2'd0)      w_err = (w_in_chan > bus.reg_chan_cnt_i);
          else if (r_ab == 2'd1) w_err = (w_in_pix > bus.reg_chan_len_i);
          else                   w_err = 1'b1;
        end
        S_DATA_WR: begin
          w_ram_we = 1'b1;
          w_done   = w_byte_last && w_pix_last && w_chan_last;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_idx <= '0; r_rd_addr <= '0; r_ab <= '0;
      r_start_chan <= '0; r_start_pix <= '0;
      r_chan <= '0; r_pix <= '0; r_byte <= '0;
      r_cnt <= '0; r_len <= '0; r_rgbw <= 1'b0;
      r_reg_wr_en <= 1'b0; r_reg_wr_addr <= '0;
      r_ram_wr_en <= '0; r_ram_addr <= '0; r_byte_en <= '0;
      r_done <= 1'b0; r_err <= 1'b0;
    end else begin
      // address/lane outputs are only non-zero alongside their strobe
      r_reg_wr_en   <= w_reg_we;
      r_reg_wr_addr <= w_reg_we ? r_idx[REG_AW-1:0] : '0;
      r_ram_wr_en   <= w_ram_we ? (CHAN_NUM'(1) << r_chan) : '0;
      r_ram_addr    <= w_ram_we ? r_pix : '0;
      r_byte_en     <= w_ram_we ? (4'b0001 << r_byte) : '0;
      r_done        <= w_done;
      r_err         <= w_err;
      if (w_cmd) begin
        r_idx <= '0;
        r_ab  <= '0;
        if (bus.spi_byte_data_i == CMD_CONF_RD) r_rd_addr <= '0;
        if (bus.spi_byte_data_i == CMD_DATA_WR) begin
          r_rgbw <= bus.reg_rgbw_i;
          r_len  <= bus.reg_chan_len_i;
          r_cnt  <= bus.reg_chan_cnt_i;
          r_chan <= r_start_chan;
          r_pix  <= r_start_pix;
          r_byte <= '0;
        end
      end else if (w_dat) begin
        case (r_state)
          S_CONF_WR: if (w_reg_we) r_idx <= r_idx + 1'b1;
          S_CONF_RD: r_rd_addr <= (r_rd_addr == REG_LAST) ? '0 : r_rd_addr + 1'b1;
          S_ADDR_WR: begin
            if (r_ab == 2'd0) begin
              r_start_chan <= w_err ? '0 : w_in_chan;
              r_ab         <= 2'd1;
            end else if (r_ab == 2'd1) begin
              r_start_pix <= w_err ? '0 : w_in_pix;
              r_ab        <= 2'd2;
            end
          end
          S_DATA_WR: begin
            if (w_done) begin
              r_start_chan <= '0;
              r_start_pix  <= '0;
            end else if (w_byte_last) begin
              r_byte <= '0;
              if (w_pix_last) begin
                r_pix  <= '0;
                r_chan <= r_chan + 1'b1;
              end else begin
                r_pix <= r_pix + 1'b1;
              end
            end else begin
              r_byte <= r_byte + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.reg_rd_addr_o    = r_rd_addr;
  assign bus.reg_wr_en_o      = r_reg_wr_en;
  assign bus.reg_wr_addr_o    = r_reg_wr_addr;
  assign bus.ram_wr_en_o      = r_ram_wr_en;
  assign bus.ram_wr_done_o    = r_done;
  assign bus.ram_wr_addr_o    = r_ram_addr;
  assign bus.ram_wr_byte_en_o = r_byte_en;
  assign bus.err_o            = r_err;
endmodule
